// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: pulls words from a host FIFO and shifts them to one of
// slave_num_c chip selects with programmable divider, CPOL/CPHA, bit order and burst hold.
module spi_master_mc #(
    parameter int unsigned data_width_c     = 8,
    parameter int unsigned slave_num_c      = 4,
    parameter int unsigned reg_addr_width_c = 2,
    parameter int unsigned reg_din_width_c  = 8,
    parameter int unsigned div_reset_c      = 2,
    localparam int unsigned addr_width_c    = (slave_num_c > 1) ? $clog2(slave_num_c) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fifo_req_data,
    input  logic                        fifo_din_valid,
    input  logic                        fifo_empty,
    input  logic [data_width_c-1:0]     fifo_din,
    input  logic [addr_width_c-1:0]     spi_slave_addr,
    input  logic [reg_addr_width_c-1:0] reg_addr,
    input  logic [reg_din_width_c-1:0]  reg_din,
    input  logic                        reg_din_val,
    output logic                        reg_ack,
    output logic                        reg_err,
    output logic                        busy,
    output logic [data_width_c-1:0]     dout,
    output logic                        dout_valid,
    output logic                        addr_err,
    output logic                        spi_clk,
    output logic                        spi_mosi,
    input  logic                        spi_miso,
    output logic [slave_num_c-1:0]      spi_ss
);

    localparam int unsigned edge_width_c = $clog2(2 * data_width_c + 1);
    localparam int unsigned last_edge_c  = 2 * data_width_c - 1;

    typedef enum logic [2:0] {
        st_idle,
        st_wait,
        st_setup,
        st_shift,
        st_hold,
        st_done,
        st_next,
        st_gap
    } state_t;

    state_t                      state_q, state_d;
    logic [reg_din_width_c-1:0]  div_q;
    logic [reg_din_width_c-1:0]  cnt_q;
    logic [edge_width_c-1:0]     edge_q;
    logic                        cpha_q, cpol_q, lsb_q, burst_q, in_burst_q;
    logic [addr_width_c-1:0]     addr_q;
    logic [data_width_c-1:0]     tx_sr_q, rx_sr_q;
    logic                        miso_meta_q, miso_sync_q;

    logic                        tick_c, addr_ok_c, same_addr_c;
    logic                        req_c, latch_c, aerr_c, load_c, edge_c;
    logic [data_width_c-1:0]     tx_word_c;

    function automatic logic [data_width_c-1:0] bit_rev(input logic [data_width_c-1:0] v);
        logic [data_width_c-1:0] r;
        for (int i = 0; i < int'(data_width_c); i++) begin
            r[i] = v[int'(data_width_c) - 1 - i];
        end
        return r;
    endfunction

    assign tick_c      = (cnt_q == div_q - reg_din_width_c'(1));
    assign addr_ok_c   = (32'(spi_slave_addr) < slave_num_c);
    assign same_addr_c = (spi_slave_addr == addr_q);
    assign tx_word_c   = lsb_q ? bit_rev(fifo_din) : fifo_din;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        latch_c = 1'b0;
        aerr_c  = 1'b0;
        load_c  = 1'b0;
        edge_c  = 1'b0;
        case (state_q)
            st_idle: begin
                if (!fifo_empty) begin
                    req_c   = 1'b1;
                    state_d = st_wait;
                end
            end
            st_wait: begin
                if (fifo_din_valid) begin
                    if (!addr_ok_c) begin
                        aerr_c  = 1'b1;
                        state_d = in_burst_q ? st_gap : st_idle;
                    end else begin
                        latch_c = 1'b1;
                        state_d = in_burst_q ? st_shift : st_setup;
                    end
                end
            end
            st_setup: begin
                if (tick_c) state_d = st_shift;
            end
            st_shift: begin
                if (tick_c) begin
                    edge_c = 1'b1;
                    if (edge_q == edge_width_c'(last_edge_c)) state_d = st_hold;
                end
            end
            st_hold: begin
                if (tick_c) state_d = st_done;
            end
            st_done: begin
                load_c  = 1'b1;
                state_d = st_next;
            end
            st_next: begin
                if (burst_q && !fifo_empty && same_addr_c) begin
                    req_c   = 1'b1;
                    state_d = st_wait;
                end else begin
                    state_d = st_gap;
                end
            end
            st_gap: begin
                if (tick_c) state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= st_idle;
        else      state_q <= state_d;
    end

    // Datapath, pin drivers and host-side strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            edge_q        <= '0;
            in_burst_q    <= 1'b0;
            addr_q        <= '0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            miso_meta_q   <= 1'b0;
            miso_sync_q   <= 1'b0;
            fifo_req_data <= 1'b0;
            addr_err      <= 1'b0;
            dout_valid    <= 1'b0;
            dout          <= '0;
            busy          <= 1'b0;
            spi_clk       <= 1'b0;
            spi_mosi      <= 1'b0;
            spi_ss        <= '1;
        end else begin
            miso_meta_q   <= spi_miso;
            miso_sync_q   <= miso_meta_q;
            fifo_req_data <= req_c;
            addr_err      <= aerr_c;
            dout_valid    <= load_c;
            busy          <= (state_d != st_idle);

            if ((state_d != state_q) || tick_c) cnt_q <= '0;
            else                                 cnt_q <= cnt_q + reg_din_width_c'(1);

            if (req_c) in_burst_q <= (state_q == st_next);

            if (latch_c) begin
                addr_q <= spi_slave_addr;
                spi_ss <= ~(slave_num_c'(1) << spi_slave_addr);
                edge_q <= '0;
                if (!cpha_q) begin
                    spi_mosi <= tx_word_c[data_width_c-1];
                    tx_sr_q  <= tx_word_c << 1;
                end else begin
                    tx_sr_q  <= tx_word_c;
                end
            end

            // Even edge index is the leading edge; CPHA picks which edge samples
            if (edge_c) begin
                edge_q <= edge_q + edge_width_c'(1);
                if ((~edge_q[0]) ^ cpha_q) begin
                    rx_sr_q <= {rx_sr_q[data_width_c-2:0], miso_sync_q};
                end else begin
                    spi_mosi <= tx_sr_q[data_width_c-1];
                    tx_sr_q  <= tx_sr_q << 1;
                end
            end

            if (state_q == st_idle) spi_clk <= cpol_q;
            else if (edge_c)        spi_clk <= ~spi_clk;

            if ((state_d == st_gap) || (state_d == st_idle)) spi_ss <= '1;

            if (load_c) dout <= lsb_q ? bit_rev(rx_sr_q) : rx_sr_q;
        end
    end

    // Configuration registers; writes are only accepted while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= reg_din_width_c'(div_reset_c);
            cpha_q  <= 1'b0;
            cpol_q  <= 1'b0;
            lsb_q   <= 1'b0;
            burst_q <= 1'b0;
            reg_ack <= 1'b0;
            reg_err <= 1'b0;
        end else begin
            reg_ack <= 1'b0;
            reg_err <= 1'b0;
            if (reg_din_val) begin
                if (busy) begin
                    reg_err <= 1'b1;
                end else if (reg_addr == reg_addr_width_c'(0)) begin
                    if (reg_din == '0) begin
                        reg_err <= 1'b1;
                    end else begin
                        div_q   <= reg_din;
                        reg_ack <= 1'b1;
                    end
                end else if (reg_addr == reg_addr_width_c'(1)) begin
                    cpha_q  <= reg_din[0];
                    cpol_q  <= reg_din[1];
                    lsb_q   <= reg_din[2];
                    reg_ack <= 1'b1;
                end else if (reg_addr == reg_addr_width_c'(2)) begin
                    burst_q <= reg_din[0];
                    reg_ack <= 1'b1;
                end else begin
                    reg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Scoreboard bench for spi_master_mc: FIFO model, behavioural SPI slave and
// dout/MOSI/latency checks. Five slaves so that address 5 is out of range.
module tb_spi_master_mc;

    localparam int unsigned W  = 8;
    localparam int unsigned NS = 5;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_req_data, fifo_din_valid, fifo_empty;
    logic [W-1:0]  fifo_din;
    logic [AW-1:0] spi_slave_addr;
    logic [1:0]    reg_addr;
    logic [7:0]    reg_din;
    logic          reg_din_val, reg_ack, reg_err, busy;
    logic [W-1:0]  dout;
    logic          dout_valid, addr_err, spi_clk, spi_mosi, spi_miso;
    logic [NS-1:0] spi_ss;

    spi_master_mc #(
        .data_width_c(W), .slave_num_c(NS), .reg_addr_width_c(2),
        .reg_din_width_c(8), .div_reset_c(2)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_req_data(fifo_req_data), .fifo_din_valid(fifo_din_valid),
        .fifo_empty(fifo_empty), .fifo_din(fifo_din), .spi_slave_addr(spi_slave_addr),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_din_val(reg_din_val),
        .reg_ack(reg_ack), .reg_err(reg_err), .busy(busy),
        .dout(dout), .dout_valid(dout_valid), .addr_err(addr_err),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } fifo_ent_t;

    fifo_ent_t    fifo_q[$];
    fifo_ent_t    cur_ent;
    logic [W-1:0] exp_rx_q[$], exp_tx_q[$], sl_q[$];
    logic         pend;
    logic         cfg_cpha = 1'b0, cfg_lsb = 1'b0;
    int           cur_d = 2;

    int unsigned tests = 0, fails = 0;
    int          cyc = 0, fall_cyc = 0, rise_cyc = 0, last_lat = 0, gap = 0;
    int          fall_cnt = 0, rise_cnt = 0, dv_cnt = 0, aerr_cnt = 0;
    logic [NS-1:0] fall_ss = '1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Host FIFO model: word follows a request by one cycle, head address always visible
    initial begin
        fifo_din_valid = 1'b0;
        fifo_din       = '0;
        spi_slave_addr = '0;
        fifo_empty     = 1'b1;
        pend           = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend           = 1'b0;
                fifo_din_valid = 1'b0;
                fifo_empty     = 1'b1;
            end else if (pend) begin
                fifo_din_valid = 1'b1;
                fifo_din       = cur_ent.data;
                spi_slave_addr = cur_ent.addr;
                pend           = 1'b0;
            end else begin
                fifo_din_valid = 1'b0;
                if (fifo_req_data && fifo_q.size() > 0) begin
                    cur_ent        = fifo_q.pop_front();
                    pend           = 1'b1;
                    spi_slave_addr = cur_ent.addr;
                end
                fifo_empty = (fifo_q.size() == 0);
                if (!pend && fifo_q.size() > 0) spi_slave_addr = fifo_q[0].addr;
            end
        end
    end

    // SPI slave, SS/latency monitor and dout scoreboard
    initial begin : mon
        int           tog, idx;
        logic         prev_clk, prev_all1, all1, sl_active;
        logic [W-1:0] sl_word, cap, last_cap;
        tog = 0; idx = 0; prev_clk = 1'b0; prev_all1 = 1'b1;
        sl_active = 1'b0; sl_word = '0; cap = '0; last_cap = '0;
        spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                sl_active = 1'b0; tog = 0; idx = 0; cap = '0;
                prev_clk = spi_clk; prev_all1 = 1'b1;
            end else begin
                all1 = (spi_ss == '1);
                if (prev_all1 && !all1) begin
                    fall_cyc = cyc; fall_cnt++; gap = cyc - rise_cyc; fall_ss = spi_ss;
                end
                if (!prev_all1 && all1) begin
                    rise_cyc = cyc; rise_cnt++;
                end
                prev_all1 = all1;
                if (!all1 && spi_clk !== prev_clk) begin
                    tog++;
                    if (((tog % 2) == 1) != cfg_cpha) begin
                        cap[cfg_lsb ? idx : int'(W) - 1 - idx] = spi_mosi;
                        idx++;
                        if (idx < int'(W)) spi_miso = sl_word[cfg_lsb ? idx : int'(W) - 1 - idx];
                    end
                    if (tog == 2 * int'(W)) begin
                        last_cap = cap; cap = '0; tog = 0; idx = 0; sl_active = 1'b0;
                    end
                end
                prev_clk = spi_clk;
                if (!sl_active && sl_q.size() > 0) begin
                    sl_word   = sl_q.pop_front();
                    sl_active = 1'b1;
                    spi_miso  = sl_word[cfg_lsb ? 0 : W - 1];
                end
                if (dout_valid) begin
                    dv_cnt++;
                    last_lat = cyc - fall_cyc;
                    if (exp_rx_q.size() == 0) begin
                        check("dout_unexpected", 32'(exp_rx_q.size()), 32'd1);
                    end else begin
                        check("dout", 32'(dout), 32'(exp_rx_q.pop_front()));
                        check("mosi_word", 32'(last_cap), 32'(exp_tx_q.pop_front()));
                        check("busy_at_dv", 32'(busy), 32'd1);
                    end
                end
                if (addr_err) aerr_cnt++;
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] sl);
        fifo_ent_t e;
        e.addr = a;
        e.data = d;
        fifo_q.push_back(e);
        if (32'(a) < NS) begin
            exp_rx_q.push_back(sl);
            exp_tx_q.push_back(d);
            sl_q.push_back(sl);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d, input logic ok, input string tag);
        @(negedge clk);
        reg_addr = a; reg_din = d; reg_din_val = 1'b1;
        @(negedge clk);
        reg_din_val = 1'b0;
        check({tag, "_ack"}, 32'(reg_ack), 32'(ok));
        check({tag, "_err"}, 32'(reg_err), 32'(!ok));
        @(negedge clk);
        check({tag, "_pulse"}, 32'({reg_ack, reg_err}), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && !pend && !busy && exp_rx_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int f0, r0, d0, a0;
        logic started;
        rst = 1'b0; reg_addr = '0; reg_din = '0; reg_din_val = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss", 32'(spi_ss), 32'h1f);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk", 32'(spi_clk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_strobes", 32'({dout_valid, fifo_req_data, reg_ack, reg_err, addr_err}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Divider writes: D=3 accepted, D=0 and address 3 rejected
        reg_write(2'd0, 8'd3, 1'b1, "wr_div3"); cur_d = 3;
        reg_write(2'd0, 8'd0, 1'b0, "wr_div0");
        reg_write(2'd3, 8'd1, 1'b0, "wr_addr3");
        send(3'd2, 8'h5A, 8'h5A);
        wait_done("done_5a");
        check("ss_slave2", 32'(fall_ss), 32'h1b);
        check("lat_d3", 32'(last_lat), 32'(cur_d * 18 + 1));

        // Default mode D=2, loopback word to slave 1, write attempt while busy
        reg_write(2'd0, 8'd2, 1'b1, "wr_div2"); cur_d = 2;
        send(3'd1, 8'hA5, 8'hA5);
        wait_busy("busy_a5");
        reg_write(2'd0, 8'd4, 1'b0, "wr_busy");
        wait_done("done_a5");
        check("ss_slave1", 32'(fall_ss), 32'h1d);
        check("lat_d2", 32'(last_lat), 32'(cur_d * 18 + 1));

        // CPOL=1 CPHA=1 LSB-first, D=1, MISO held high
        reg_write(2'd1, 8'h07, 1'b1, "wr_mode");
        cfg_cpha = 1'b1; cfg_lsb = 1'b1;
        reg_write(2'd0, 8'd1, 1'b1, "wr_div1"); cur_d = 1;
        check("cpol_idle", 32'(spi_clk), 32'd1);
        send(3'd0, 8'h01, 8'hFF);
        wait_done("done_mode3");
        check("lat_d1", 32'(last_lat), 32'(cur_d * 18 + 1));

        // Burst hold, three words to slave 0
        reg_write(2'd1, 8'h00, 1'b1, "wr_mode0");
        cfg_cpha = 1'b0; cfg_lsb = 1'b0;
        reg_write(2'd0, 8'd2, 1'b1, "wr_div2b"); cur_d = 2;
        check("cpol0_idle", 32'(spi_clk), 32'd0);
        reg_write(2'd2, 8'd1, 1'b1, "wr_burst");
        f0 = fall_cnt; r0 = rise_cnt; d0 = dv_cnt;
        send(3'd0, 8'h11, 8'h11);
        send(3'd0, 8'h22, 8'h22);
        send(3'd0, 8'h33, 8'h33);
        wait_done("done_burst");
        check("burst_falls", 32'(fall_cnt - f0), 32'd1);
        check("burst_rises", 32'(rise_cnt - r0), 32'd1);
        check("burst_dv", 32'(dv_cnt - d0), 32'd3);

        // Burst with a slave change must drop SS for at least D cycles
        f0 = fall_cnt; r0 = rise_cnt;
        send(3'd0, 8'h44, 8'h44);
        send(3'd2, 8'h55, 8'h55);
        wait_done("done_burst2");
        check("burst2_falls", 32'(fall_cnt - f0), 32'd2);
        check("burst2_gap", 32'(gap >= cur_d), 32'd1);
        check("burst2_ss", 32'(fall_ss), 32'h1b);

        // Out-of-range address
        f0 = fall_cnt; d0 = dv_cnt; a0 = aerr_cnt;
        send(3'd5, 8'h66, 8'h00);
        wait_done("done_aerr");
        check("aerr_pulse", 32'(aerr_cnt - a0), 32'd1);
        check("aerr_no_ss", 32'(fall_cnt - f0), 32'd0);
        check("aerr_no_dv", 32'(dv_cnt - d0), 32'd0);

        // Reset in the middle of a shift
        send(3'd3, 8'h77, 8'h77);
        started = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_ss != '1) begin
                started = 1'b1;
                break;
            end
        end
        check("mid_ss_low", 32'(started), 32'd1);
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ss", 32'(spi_ss), 32'h1f);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_clk", 32'(spi_clk), 32'd0);
        fifo_q.delete(); exp_rx_q.delete(); exp_tx_q.delete(); sl_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cur_d = 2;

        // Registers return to reset defaults: D=2, no burst
        send(3'd1, 8'h3C, 8'h3C);
        wait_done("done_post_rst");
        check("post_rst_lat", 32'(last_lat), 32'(cur_d * 18 + 1));
        check("post_rst_ss", 32'(fall_ss), 32'h1d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
